ti_nibble_masker: RTL
=====================

# ti_nibble_masker

Sequential front-end that turns plain 4-bit S-box input nibbles into the 2-share, 8-bit shared word consumed by the threshold-implementation S-box share functions. Each accepted nibble x gets a fresh 4-bit mask r from an internal Galois LFSR, producing share0 = x ^ r and share1 = r. Output is packed as {share1, share0}: bits [3:0] = share0, bits [7:4] = share1. The block sits between the unmasked datapath and the TI S-box layer and uses a valid/ready handshake on both sides.

## Interface
- LFSR_W, 16, LFSR width in bits
- LFSR_TAPS, 16'hB400, Galois feedback mask
- SEED_DEFAULT, 16'hACE1, LFSR value loaded by reset (the block still waits for an explicit seed)
- clk  in  1  single clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- seed_valid  in  1  load seed_data into the LFSR this cycle
- seed_data  in  LFSR_W  new LFSR state; must be nonzero
- in_valid  in  1  in_data is valid
- in_data  in  4  unshared nibble x
- in_ready  out  1  nibble accepted when in_valid & in_ready
- out_valid  out  1  out_data is valid
- out_data  out  8  {share1, share0}
- out_ready  in  1  downstream accepts when out_valid & out_ready
- err_zero_seed  out  1  one-cycle pulse when a zero seed is rejected
- mask_count  out  16  number of accepted nibbles; saturates at 16'hFFFF

## Operation
- FSM states: UNSEEDED, RUN. Reset enters UNSEEDED with lfsr = SEED_DEFAULT, out_valid = 0, out_data = 0, mask_count = 0, err_zero_seed = 0.
- UNSEEDED: in_ready = 0. A seed_valid with nonzero seed_data loads the LFSR and moves to RUN. A seed_valid with zero seed_data pulses err_zero_seed, and the FSM stays in UNSEEDED.
- RUN: in_ready = !out_valid | out_ready, so the single output register may be refilled in the same cycle it drains.
- On accept: r = lfsr[3:0]; out_data <= {r, in_data ^ r}; out_valid <= 1; lfsr advances exactly 4 Galois steps; mask_count increments unless it is already 16'hFFFF.
- Galois step: lsb = s[0]; s = s >> 1; if lsb, s = s ^ LFSR_TAPS.
- With no accept, the LFSR holds its value. The mask is never reused.
- out_valid clears when out_ready is high and no new accept occurs in that cycle. While out_valid & !out_ready, out_data is held stable.
- Seed load in RUN with a nonzero value: the LFSR takes seed_data. If an accept happens in the same cycle, that accept uses the old lfsr[3:0], and the seed load wins over the 4-step advance.
- Seed load in RUN with a zero value: ignored, err_zero_seed pulses, and the FSM stays in RUN.
- Invariant: out_data[3:0] ^ out_data[7:4] equals the accepted nibble.

## Timing
- Latency is 1 cycle: a nibble accepted in cycle n appears on out_data with out_valid in cycle n+1.
- Throughput is 1 nibble per cycle when out_ready is held high.
- in_ready is combinational from the FSM state, out_valid and out_ready. There is no combinational path from in_valid to any output.
- rst asserted mid-operation drops any pending output at the next edge (out_valid = 0) and returns the block to UNSEEDED.
- err_zero_seed is registered and asserts in the cycle after the rejected seed.

## Structure
- Package ti_pkg holds:
  - SHARE_W = 4 and NSHARES = 2;
  - default taps and seed;
  - a state enum for UNSEEDED and RUN;
  - a function lfsr_step4 that unrolls 4 Galois steps.
- Sub-module ti_mask_lfsr holds the LFSR register, the load/advance priority and the zero-seed check, and exports mask[3:0].
- The top module holds the FSM, the output register, the handshake logic and mask_count.

## Test plan
- Seed and first nibble: after reset, drive seed 16'hACE1, then in_data 4'h5 → out_data 8'h14 one cycle later. lfsr becomes 16'h1C4E.
- Back-to-back: a second in_data 4'h5 immediately after the first → out_data 8'hEB. mask_count reads 2.
- Backpressure: hold out_ready = 0 for 5 cycles with out_valid = 1 → in_ready = 0, out_data is stable and the LFSR does not advance. Releasing out_ready lets a new accept happen in the same cycle.
- Seed rejection:
  - a zero seed in UNSEEDED → err_zero_seed pulses and in_ready stays 0;
  - a zero seed in RUN → err_zero_seed pulses and the LFSR is unchanged.
- Reseed during accept: a seed 16'h0001 together with in_data 4'h0 → the output uses the old mask, and the next accept uses mask 4'h1.
- Reset mid-stream plus random soak: rst with out_valid = 1 → out_valid = 0 and the FSM returns to UNSEEDED. Over 10k random nibbles with random out_ready, the XOR of the two shares equals the input every time and no output is lost or duplicated.

Source files
------------

// File: rtl/ti_pkg.sv
// Shared constants, state encoding and the 4-step Galois LFSR update for the
// threshold-implementation nibble masker.
package ti_pkg;

  localparam int SHARE_W     = 4;
  localparam int NSHARES     = 2;
  localparam int LFSR_W_DFLT = 16;

  localparam logic [LFSR_W_DFLT-1:0] TAPS_DFLT = 16'hB400;
  localparam logic [LFSR_W_DFLT-1:0] SEED_DFLT = 16'hACE1;

  typedef enum logic {
    ST_UNSEEDED = 1'b0,
    ST_RUN      = 1'b1
  } ti_state_e;

  // Four right-shifting Galois steps, so every mask nibble is fresh LFSR output.
  function automatic logic [LFSR_W_DFLT-1:0] lfsr_step4(
    input logic [LFSR_W_DFLT-1:0] s,
    input logic [LFSR_W_DFLT-1:0] taps
  );
    logic [LFSR_W_DFLT-1:0] v;
    v = s;
    for (int i = 0; i < 4; i++) begin
      if (v[0]) v = (v >> 1) ^ taps;
      else      v = v >> 1;
    end
    return v;
  endfunction

endpackage

// File: rtl/ti_mask_lfsr.sv
// Mask generator: LFSR register with seed load taking priority over the
// per-accept advance; zero seeds are refused and flagged.
module ti_mask_lfsr
  import ti_pkg::*;
#(
  parameter int                LFSR_W       = LFSR_W_DFLT,
  parameter logic [LFSR_W-1:0] LFSR_TAPS    = TAPS_DFLT,
  parameter logic [LFSR_W-1:0] SEED_DEFAULT = SEED_DFLT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,
  input  logic [LFSR_W-1:0]  seed_i,
  input  logic               adv_i,
  output logic [SHARE_W-1:0] mask_o,
  output logic               seed_ok_o,
  output logic               zero_seed_o
);

  logic [LFSR_W-1:0] lfsr_q;
  logic [LFSR_W-1:0] lfsr_d;

  assign seed_ok_o   = load_i && (seed_i != '0);
  assign zero_seed_o = load_i && (seed_i == '0);
  assign mask_o      = lfsr_q[SHARE_W-1:0];

  always_comb begin
    lfsr_d = lfsr_q;
    if (seed_ok_o)  lfsr_d = seed_i;
    else if (adv_i) lfsr_d = lfsr_step4(lfsr_q, LFSR_TAPS);
  end

  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= SEED_DEFAULT;
    else     lfsr_q <= lfsr_d;
  end

endmodule

// File: rtl/ti_nibble_masker.sv
// Turns plain nibbles into {share1, share0} = {r, x ^ r} with a one-entry
// output register and valid/ready handshakes on both sides.
module ti_nibble_masker
  import ti_pkg::*;
#(
  parameter int                LFSR_W       = LFSR_W_DFLT,
  parameter logic [LFSR_W-1:0] LFSR_TAPS    = TAPS_DFLT,
  parameter logic [LFSR_W-1:0] SEED_DEFAULT = SEED_DFLT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       seed_valid,
  input  logic [LFSR_W-1:0]          seed_data,
  input  logic                       in_valid,
  input  logic [SHARE_W-1:0]         in_data,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [NSHARES*SHARE_W-1:0] out_data,
  input  logic                       out_ready,
  output logic                       err_zero_seed,
  output logic [15:0]                mask_count
);

  ti_state_e                  state_q, state_d;
  logic                       out_valid_q, out_valid_d;
  logic [NSHARES*SHARE_W-1:0] out_data_q, out_data_d;
  logic [15:0]                count_q, count_d;
  logic                       err_q, err_d;
  logic                       accept;
  logic                       seed_ok;
  logic                       zero_seed;
  logic [SHARE_W-1:0]         mask;

  ti_mask_lfsr #(
    .LFSR_W       (LFSR_W),
    .LFSR_TAPS    (LFSR_TAPS),
    .SEED_DEFAULT (SEED_DEFAULT)
  ) u_lfsr (
    .clk         (clk),
    .rst         (rst),
    .load_i      (seed_valid),
    .seed_i      (seed_data),
    .adv_i       (accept),
    .mask_o      (mask),
    .seed_ok_o   (seed_ok),
    .zero_seed_o (zero_seed)
  );

  // Refill is allowed in the same cycle the output register drains.
  assign in_ready = (state_q == ST_RUN) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    count_d     = count_q;
    err_d       = zero_seed;
    if (state_q == ST_UNSEEDED && seed_ok) state_d = ST_RUN;
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = {mask, in_data ^ mask};
      if (count_q != 16'hFFFF) count_d = count_q + 16'd1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_UNSEEDED;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      count_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      count_q     <= count_d;
      err_q       <= err_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign out_data      = out_data_q;
  assign mask_count    = count_q;
  assign err_zero_seed = err_q;

endmodule
